// File: rtl/cpu_io_pkg.sv
// Shared word, timestamp and FIFO entry types for the CPUOut capture path.
package cpu_io_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TS_W   = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TS_W-1:0]   tstamp_t;

  typedef struct packed {
    word_t   data;
    tstamp_t ts;
  } entry_t;

endpackage

// File: rtl/cpu_out_capture_if.sv
// Valid/ready output stream of cpu_out_capture plus occupancy/status.
// out_tstamp exists only when CPUOUT_TSTAMP_EN is defined.
interface cpu_out_capture_if
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = WORD_W
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             full;
  logic             overflow;
`ifdef CPUOUT_TSTAMP_EN
  tstamp_t          out_tstamp;

  modport master (
    output out_data, out_valid, out_count, full, overflow, out_tstamp,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_count, full, overflow, out_tstamp,
    output out_ready
  );
`else
  modport master (
    output out_data, out_valid, out_count, full, overflow,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_count, full, overflow,
    output out_ready
  );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO; full/empty derive from the occupancy count.
// Caller guarantees push is only requested when a slot exists (or a pop frees one).
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           wdata_i,
  output T                           rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, full_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/cpu_out_capture.sv
// Captures every change of the CPU output word into a FIFO served on a valid/ready stream.
// Optional CPUOUT_TSTAMP_EN stores a 16-bit cycle stamp with each entry.
module cpu_out_capture
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] CPUOut,
  cpu_out_capture_if.master out_if
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] last_q;
  logic             overflow_q;
  logic             chg_c, pop_c, push_c;
  logic             fifo_valid, fifo_full;
  logic [CNT_W-1:0] fifo_count;

  assign chg_c  = (CPUOut != last_q);
  assign pop_c  = fifo_valid && out_if.out_ready;
  assign push_c = chg_c && (!fifo_full || pop_c);

  // last_q follows CPUOut even when a word is dropped, so it is never retried.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      last_q <= CPUOut;
      if (chg_c && fifo_full && !pop_c) overflow_q <= 1'b1;
    end
  end

`ifdef CPUOUT_TSTAMP_EN
  tstamp_t tstamp_q;
  entry_t  wr_entry, rd_entry;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) tstamp_q <= '0;
    else       tstamp_q <= tstamp_q + 16'(1);
  end

  assign wr_entry = '{data: word_t'(CPUOut), ts: tstamp_q};

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (CLK),
    .rst     (Reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign out_if.out_data   = WIDTH'(rd_entry.data);
  assign out_if.out_tstamp = rd_entry.ts;
`else
  logic [WIDTH-1:0] rd_word;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [WIDTH-1:0])
  ) u_fifo (
    .clk     (CLK),
    .rst     (Reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (CPUOut),
    .rdata_o (rd_word),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign out_if.out_data = rd_word;
`endif

  assign out_if.out_valid = fifo_valid;
  assign out_if.out_count = fifo_count;
  assign out_if.full      = fifo_full;
  assign out_if.overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_out_capture.sv
// Self-checking bench for cpu_out_capture: vector table, corner sequences, random vs queue model.
module tb_cpu_out_capture;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] CPUOut = '0;

  cpu_out_capture_if #(.DEPTH(DEPTH), .WIDTH(32)) bus ();

  cpu_out_capture #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .CPUOut (CPUOut),
    .out_if (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a queue of captured words with their push-edge stamps.
  logic [31:0] m_q[$];
  int          m_ts[$];
  logic [31:0] m_last;
  bit          m_ovf;
  int          m_cyc;

  typedef struct {
    logic [31:0] cpu;
    logic        rdy;
    logic        valid;
    int          count;
    logic [31:0] data;
    bit          chk_data;
    logic        full;
    logic        ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_cyc  = 0;
  endtask

  task automatic model_edge(input logic [31:0] cpu, input logic rdy);
    bit pop, chg, was_full;
    pop      = (m_q.size() > 0) && rdy;
    chg      = (cpu != m_last);
    was_full = (m_q.size() == DEPTH);
    if (pop) begin
      void'(m_q.pop_front());
      void'(m_ts.pop_front());
    end
    if (chg && (!was_full || pop)) begin
      m_q.push_back(cpu);
      m_ts.push_back(m_cyc);
    end
    if (chg && was_full && !pop) m_ovf = 1'b1;
    m_last = cpu;
    m_cyc  = (m_cyc + 1) % 65536;
  endtask

  task automatic check_model();
    chk("valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("count", 32'(bus.out_count), 32'(m_q.size()));
    chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("data", bus.out_data, m_q[0]);
`ifdef CPUOUT_TSTAMP_EN
      chk("tstamp", 32'(bus.out_tstamp), 32'(m_ts[0]));
`endif
    end
  endtask

  // One clock: drive inputs, take the edge, then compare against the model.
  task automatic cycle(input logic [31:0] cpu, input logic rdy);
    CPUOut        = cpu;
    bus.out_ready = rdy;
    @(posedge CLK);
    model_edge(cpu, rdy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset         = 1'b1;
    CPUOut        = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   exp_drain[$];

    // Single word held for three cycles, then 1..9 into a full FIFO, then drain.
    vecs.push_back('{32'd5, 1'b1, 1'b1, 1, 32'd5, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'd5, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'd5, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{32'(i), 1'b0, 1'b1, i, 32'd1, 1'b1, logic'(i == 8), 1'b0});
    vecs.push_back('{32'd9, 1'b0, 1'b1, 8, 32'd1, 1'b1, 1'b1, 1'b1});
    for (int i = 1; i <= 7; i++)
      vecs.push_back('{32'd9, 1'b1, 1'b1, 8 - i, 32'(i + 1), 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'd9, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b1});

    bus.out_ready = 1'b0;
    model_reset();
    #12;
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) cycle(32'd0, 1'b0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_count", 32'(bus.out_count), 32'd0);
    chk("idle_ovf", 32'(bus.overflow), 32'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      cycle(v.cpu, v.rdy);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(v.valid));
      chk($sformatf("vec%0d_count", i), 32'(bus.out_count), 32'(v.count));
      chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(v.full));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(v.ovf));
      if (v.chk_data) chk($sformatf("vec%0d_data", i), bus.out_data, v.data);
    end

    // Full FIFO with a pop and a change on the same edge.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(32'(i), 1'b0);
    chk("sim_full_pre", 32'(bus.out_count), 32'd8);
    cycle(32'd20, 1'b1);
    chk("sim_count", 32'(bus.out_count), 32'd8);
    chk("sim_ovf", 32'(bus.overflow), 32'd0);
    exp_drain = '{2, 3, 4, 5, 6, 7, 8, 20};
    foreach (exp_drain[i]) begin
      chk($sformatf("sim_drain%0d", i), bus.out_data, 32'(exp_drain[i]));
      cycle(32'd20, 1'b1);
    end
    chk("sim_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-cycle with four entries queued.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(32'(i + 40), 1'b0);
    chk("pre_rst_count", 32'(bus.out_count), 32'd4);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_count", 32'(bus.out_count), 32'd0);
    chk("async_rst_full", 32'(bus.full), 32'd0);
    model_reset();
    CPUOut        = '0;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;

`ifdef CPUOUT_TSTAMP_EN
    // Pushes on the 4th and 8th edges after reset carry stamps 3 and 7.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(32'd0, 1'b0);
    cycle(32'd11, 1'b0);
    chk("ts_first", 32'(bus.out_tstamp), 32'd3);
    for (int i = 0; i < 3; i++) cycle(32'd11, 1'b0);
    cycle(32'd12, 1'b0);
    chk("ts_head_held", 32'(bus.out_tstamp), 32'd3);
    cycle(32'd12, 1'b1);
    chk("ts_second", 32'(bus.out_tstamp), 32'd7);
    chk("ts_second_data", bus.out_data, 32'd12);
`endif

    // Random phase: small value alphabet for repeats, ready bias varies to fill and drain.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic rdy;
      case ((i / 100) % 3)
        0:       rdy = ($urandom_range(0, 3) == 0);
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = $urandom_range(0, 1) == 1;
      endcase
      cycle(32'($urandom_range(0, 3)), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
